// File: rtl/noc_rr_arbiter.sv
// Output-port arbiter for the NoC router. It picks one requesting input by round-robin and drives
// a one-hot crossbar select from the owner register. RTS/DCTS flow control runs towards the
// downstream router. An owner keeps the port for a whole packet, up to its tail flit. Otherwise
// an owner gives up the port after MAX_HOLD transfers when another input is waiting.
module noc_rr_arbiter #(
   parameter int unsigned NUM_PORTS = 5,
   parameter bit          LOCK_PKT  = 1'b1,
   parameter int unsigned MAX_HOLD  = 4,
   parameter int unsigned CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [NUM_PORTS-1:0] tail_i,
   input  logic                 dcts_i,
   output logic [NUM_PORTS-1:0] grant_o,
   output logic [NUM_PORTS-1:0] xbar_sel,
   output logic                 rts_o
);

   localparam int unsigned      IDX_W    = $clog2(NUM_PORTS);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

   logic [NUM_PORTS-1:0] r_owner;
   logic [NUM_PORTS-1:0] w_owner_d;
   logic                 r_rts;
   logic                 w_rts_d;
   logic [IDX_W-1:0]     r_last;
   logic [IDX_W-1:0]     w_last_d;
   logic                 r_locked;
   logic                 w_locked_d;
   logic [CNT_W-1:0]     r_hold;
   logic [CNT_W-1:0]     w_hold_d;

   logic                 w_busy;
   logic                 w_xfer;
   logic                 w_stall;
   logic                 w_own_req;
   logic                 w_own_tail;
   logic                 w_other_req;
   logic                 w_hold_full;
   logic                 w_owner_chg;
   logic [NUM_PORTS-1:0] w_scan_sel;
   logic [IDX_W-1:0]     w_scan_idx;

   assign w_busy      = |r_owner;
   assign w_xfer      = r_rts & dcts_i;
   assign w_stall     = r_rts & ~dcts_i;
   assign w_own_req   = |(req_i & r_owner);
   assign w_own_tail  = |(tail_i & r_owner);
   assign w_other_req = |(req_i & ~r_owner);
   assign w_hold_full = (MAX_HOLD > 0) && (r_hold == HOLD_MAX);

   // Round-robin search starting just after the last owner, so the last owner is checked last.
   always_comb begin
      logic        hit;
      int unsigned k;
      hit        = 1'b0;
      k          = 0;
      w_scan_sel = '0;
      w_scan_idx = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         k = (32'(r_last) + i) % NUM_PORTS;
         if (!hit && req_i[k[IDX_W-1:0]]) begin
            hit                         = 1'b1;
            w_scan_idx                  = k[IDX_W-1:0];
            w_scan_sel[k[IDX_W-1:0]]    = 1'b1;
         end
      end
   end

   // Next-state logic: owner arbitration, RTS handshake, packet lock and hold counting.
   always_comb begin
      w_owner_d = r_owner;
      // An unacknowledged RTS freezes the owner, so the select never moves under a pending flit.
      if (!w_stall) begin
         if (LOCK_PKT && r_locked && w_own_req) begin
            w_owner_d = r_owner;
         end else if (w_own_req && !(w_hold_full && w_other_req)) begin
            w_owner_d = r_owner;
         end else begin
            w_owner_d = w_scan_sel;
         end
      end
      w_owner_chg = (w_owner_d != r_owner);

      w_rts_d = w_busy & ~w_xfer;

      w_last_d = r_last;
      if (w_owner_chg && (|w_owner_d)) begin
         w_last_d = w_scan_idx;
      end

      w_locked_d = r_locked;
      if (w_xfer && w_busy) begin
         w_locked_d = ~w_own_tail;
      end
      // A locked owner that drops its request is a protocol error; release the lock.
      if (r_locked && !w_own_req) begin
         w_locked_d = 1'b0;
      end
      if (w_owner_chg || !LOCK_PKT) begin
         w_locked_d = 1'b0;
      end

      w_hold_d = r_hold;
      if (w_owner_chg || !(|w_owner_d)) begin
         w_hold_d = '0;
      end else if (w_xfer && (MAX_HOLD > 0) && !w_hold_full) begin
         w_hold_d = r_hold + 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner  <= '0;
         r_rts    <= 1'b0;
         r_last   <= LAST_RST;
         r_locked <= 1'b0;
         r_hold   <= '0;
      end else begin
         r_owner  <= w_owner_d;
         r_rts    <= w_rts_d;
         r_last   <= w_last_d;
         r_locked <= w_locked_d;
         r_hold   <= w_hold_d;
      end
   end

   assign xbar_sel = r_owner;
   assign rts_o    = r_rts;
   assign grant_o  = r_owner & {NUM_PORTS{w_xfer}};

   a_owner_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_owner));
   a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_o));

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: directed scenarios plus randomized traffic compared
// against a cycle-level reference model that works with integer port indices.
module tb_noc_rr_arbiter;

   localparam int unsigned N        = 5;
   localparam int unsigned MAX_HOLD = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req_i;
   logic [N-1:0] tail_i;
   logic         dcts_i;
   logic [N-1:0] grant_o;
   logic [N-1:0] xbar_sel;
   logic         rts_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   noc_rr_arbiter #(
      .NUM_PORTS(N),
      .LOCK_PKT (1'b1),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req_i   (req_i),
      .tail_i  (tail_i),
      .dcts_i  (dcts_i),
      .grant_o (grant_o),
      .xbar_sel(xbar_sel),
      .rts_o   (rts_o)
   );

   // ---------------- reference model ----------------
   int m_owner  = -1;   // -1 means no owner
   int m_last   = N - 1;
   int m_hold   = 0;
   bit m_rts    = 1'b0;
   bit m_locked = 1'b0;

   function automatic bit has(logic [N-1:0] v, int k);
      return ((v >> k) & N'(1)) != '0;
   endfunction

   function automatic logic [N-1:0] onehot(int idx);
      return (idx >= 0) ? (N'(1) << idx) : '0;
   endfunction

   function automatic int idx_of(logic [N-1:0] v);
      for (int k = 0; k < N; k++) if (has(v, k)) return k;
      return -1;
   endfunction

   function automatic int arbitrate(int owner, int last, bit locked, int hold, logic [N-1:0] req);
      bit own_req = (owner >= 0) && has(req, owner);
      bit others  = 1'b0;
      for (int k = 0; k < N; k++) if (k != owner && has(req, k)) others = 1'b1;
      if (locked && own_req) return owner;
      if (own_req && !(MAX_HOLD > 0 && hold == MAX_HOLD && others)) return owner;
      for (int i = 1; i <= N; i++) if (has(req, (last + i) % N)) return (last + i) % N;
      return -1;
   endfunction

   always @(posedge clk) begin
      int nxt;
      bit xfer;
      bit own_req;
      if (rst) begin
         m_owner  <= -1;
         m_rts    <= 1'b0;
         m_last   <= N - 1;
         m_locked <= 1'b0;
         m_hold   <= 0;
      end else begin
         xfer    = m_rts && dcts_i;
         own_req = (m_owner >= 0) && has(req_i, m_owner);
         nxt     = (m_rts && !dcts_i) ? m_owner
                                      : arbitrate(m_owner, m_last, m_locked, m_hold, req_i);
         m_rts   <= (m_owner >= 0) && !xfer;
         m_owner <= nxt;
         if (nxt >= 0) m_last <= nxt;
         if (nxt != m_owner) begin
            m_locked <= 1'b0;
            m_hold   <= 0;
         end else begin
            if (m_locked && !own_req) m_locked <= 1'b0;
            else if (xfer && m_owner >= 0) m_locked <= !has(tail_i, m_owner);
            if (xfer && m_owner >= 0 && m_hold < MAX_HOLD) m_hold <= m_hold + 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst    = 1'b1;
      req_i  = '0;
      tail_i = '0;
      dcts_i = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst    = 1'b1;
      req_i  = 5'h1F;
      tail_i = 5'h1F;
      dcts_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (rts_o !== 1'b0 || xbar_sel !== 5'b00000 || grant_o !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold: rts=%b xbar=%b grant=%b, expected 0/00000/00000",
                     rts_o, xbar_sel, grant_o);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (xbar_sel !== 5'b00001 || rts_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_c1: xbar=%b rts=%b, expected 00001/0", xbar_sel, rts_o);
      end
      tick();
      checks++;
      if (rts_o !== 1'b1 || grant_o !== 5'b00001) begin
         errors++;
         $display("FAIL reset_release_c2: rts=%b grant=%b, expected 1/00001", rts_o, grant_o);
      end
   endtask

   task automatic test_single();
      logic [N-1:0] exp_grant [4] = '{5'b00000, 5'b00100, 5'b00000, 5'b00100};
      bit           exp_rts   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      apply_reset();
      req_i  = 5'b00100;
      tail_i = 5'b11111;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (xbar_sel !== 5'b00100 || rts_o !== exp_rts[c] || grant_o !== exp_grant[c]) begin
            errors++;
            $display("FAIL single_c%0d: xbar=%b rts=%b grant=%b, expected 00100/%b/%b",
                     c + 1, xbar_sel, rts_o, grant_o, exp_rts[c], exp_grant[c]);
         end
      end
   endtask

   // Grant order under continuous requests: runs of MAX_HOLD grants per port in ring order.
   task automatic test_rotation(string name, logic [N-1:0] req, int ports [3], int nports);
      int cnt = 0;
      apply_reset();
      req_i  = req;
      tail_i = '1;
      for (int c = 0; c < 150 && cnt < 16; c++) begin
         #1;
         if (grant_o !== '0) begin
            checks++;
            if (idx_of(grant_o) != ports[(cnt / MAX_HOLD) % nports] || !$onehot(grant_o)) begin
               errors++;
               $display("FAIL %s_grant%0d: grant=%b, expected port %0d", name, cnt, grant_o,
                        ports[(cnt / MAX_HOLD) % nports]);
            end
            cnt++;
         end
         tick();
      end
      checks++;
      if (cnt != 16) begin
         errors++;
         $display("FAIL %s_count: saw %0d grants, expected 16 within budget", name, cnt);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      req_i  = 5'b01000;
      tail_i = '1;
      tick();
      tick();
      req_i  = 5'b00001;
      dcts_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (xbar_sel !== 5'b01000 || rts_o !== 1'b1 || grant_o !== 5'b00000) begin
            errors++;
            $display("FAIL stall_c%0d: xbar=%b rts=%b grant=%b, expected 01000/1/00000",
                     c, xbar_sel, rts_o, grant_o);
         end
         tick();
      end
      dcts_i = 1'b1;
      #1;
      checks++;
      if (grant_o !== 5'b01000) begin
         errors++;
         $display("FAIL stall_release: grant=%b, expected 01000", grant_o);
      end
      tick();
      checks++;
      if (xbar_sel !== 5'b00001 || grant_o !== 5'b00000) begin
         errors++;
         $display("FAIL stall_handover: xbar=%b grant=%b, expected 00001/00000",
                  xbar_sel, grant_o);
      end
   endtask

   task automatic test_lock();
      int p1   = 0;
      bit done = 1'b0;
      apply_reset();
      req_i  = 5'b00010;
      tail_i = 5'b00000;
      tick();
      for (int c = 0; c < 80 && !done; c++) begin
         req_i  = (p1 < 6) ? 5'b00011 : 5'b00001;
         tail_i = (p1 == 5) ? 5'b00011 : 5'b00001;
         #1;
         if (grant_o === 5'b00010) p1++;
         else if (grant_o === 5'b00001) done = 1'b1;
         tick();
      end
      checks++;
      if (!done || p1 != 6) begin
         errors++;
         $display("FAIL lock_packet: port1 grants=%0d before port0 (port0 granted=%0d), expected 6/1",
                  p1, done);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] exp_grant;
      apply_reset();
      for (int c = 0; c < 800; c++) begin
         rst    = ($urandom_range(60) == 0);
         req_i  = N'($urandom) | N'($urandom);
         tail_i = N'($urandom) & N'($urandom);
         dcts_i = ($urandom_range(3) != 0);
         #1;
         exp_grant = (m_rts && dcts_i) ? onehot(m_owner) : '0;
         checks++;
         if (xbar_sel !== onehot(m_owner)) begin
            errors++;
            $display("FAIL random_xbar cyc%0d: xbar=%b, expected %b", c, xbar_sel,
                     onehot(m_owner));
         end
         checks++;
         if (rts_o !== m_rts) begin
            errors++;
            $display("FAIL random_rts cyc%0d: rts=%b, expected %b", c, rts_o, m_rts);
         end
         checks++;
         if (grant_o !== exp_grant) begin
            errors++;
            $display("FAIL random_grant cyc%0d: grant=%b, expected %b", c, grant_o, exp_grant);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      int rr_ports [3] = '{0, 2, 4};
      int fair_ports [3] = '{0, 1, 0};
      rst    = 1'b1;
      req_i  = '0;
      tail_i = '0;
      dcts_i = 1'b1;
      test_reset();
      test_single();
      test_rotation("round_robin", 5'b10101, rr_ports, 3);
      test_rotation("fairness", 5'b00011, fair_ports, 2);
      test_stall();
      test_lock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
